// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared types and default constants for the echo processor
package echo_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD    = 3'd2,
        ST_MIX   = 3'd3,
        ST_WR    = 3'd4
    } state_t;

    localparam int DATA_W_DEF    = 12;
    localparam int ADDR_W_DEF    = 8;
    localparam int DELAY_RST_DEF = 64;

    // Offset-binary midscale for the default sample width (silence on the DAC).
    localparam logic [DATA_W_DEF-1:0] MIDSCALE = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature encoder synchronizer, step decode and saturating delay counter
module quad_decoder
    import echo_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DELAY_RST = DELAY_RST_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enc_a_i,
    input  logic              enc_b_i,
    output logic [ADDR_W-1:0] delay_o
);

    localparam logic [ADDR_W-1:0] DLY_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] DLY_MIN = ADDR_W'(1);

    logic [1:0]        sync1_q;
    logic [1:0]        sync2_q;
    logic [1:0]        prev_q;
    logic [ADDR_W-1:0] delay_q;
    logic [ADDR_W-1:0] delay_d;

    // Two-flop synchronizer for {A,B} plus one history stage to detect entry into 00.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
        end else begin
            sync1_q <= {enc_a_i, enc_b_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Step only on arrival at 00; coming from 11 changed both phases and is treated as noise.
    always_comb begin
        delay_d = delay_q;
        if ((sync2_q == 2'b00) && (prev_q != 2'b00)) begin
            if ((prev_q == 2'b01) && (delay_q != DLY_MAX)) begin
                delay_d = delay_q + ADDR_W'(1);
            end else if ((prev_q == 2'b10) && (delay_q != DLY_MIN)) begin
                delay_d = delay_q - ADDR_W'(1);
            end
        end
    end

    // Delay counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            delay_q <= ADDR_W'(DELAY_RST);
        end else begin
            delay_q <= delay_d;
        end
    end

    assign delay_o = delay_q;

endmodule

// File: rtl/echo_processor.sv
// rtl/echo_processor.sv - delay-line echo processor with buffer clear, feedback mix and encoder-set delay
module echo_processor
    import echo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DELAY_RST = DELAY_RST_DEF
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic              encA,
    input  logic              encB,
    input  logic              sample_in,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic [ADDR_W-1:0] delay,
    output logic              ready,
    output logic              overrun
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] MID   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] LAST  = {ADDR_W{1'b1}};

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] dly_q;
    logic [DATA_W-1:0] x_q;
    logic              mode_q;
    logic              en_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] y_q;
    logic [DATA_W-1:0] dac_data_q;
    logic              dac_valid_q;
    logic              overrun_q;

    logic              ready_c;
    logic              clr_we_c;
    logic              latch_c;
    logic              mix_c;
    logic              wr_c;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0]        x_in;
    logic signed [DATA_W:0]   sum;
    logic [DATA_W-1:0]        y_mix;
    logic [ADDR_W-1:0]        enc_delay;

    quad_decoder #(
        .ADDR_W    (ADDR_W),
        .DELAY_RST (DELAY_RST)
    ) u_quad_decoder (
        .clk_i   (sclk),
        .rst_i   (reset),
        .enc_a_i (encA),
        .enc_b_i (encB),
        .delay_o (enc_delay)
    );

    // FSM state register.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear sweep, then a fixed IDLE->RD->MIX->WR pass per sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt_q == LAST) state_d = ST_IDLE;
            ST_IDLE:  if (sample_in) state_d = ST_RD;
            ST_RD:    state_d = ST_MIX;
            ST_MIX:   state_d = ST_WR;
            ST_WR:    state_d = ST_IDLE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // FSM outputs: per-state strobes that drive the datapath.
    always_comb begin
        ready_c  = 1'b0;
        clr_we_c = 1'b0;
        latch_c  = 1'b0;
        mix_c    = 1'b0;
        wr_c     = 1'b0;
        case (state_q)
            ST_CLEAR: clr_we_c = 1'b1;
            ST_IDLE: begin
                ready_c = 1'b1;
                latch_c = sample_in;
            end
            ST_MIX:   mix_c = 1'b1;
            ST_WR:    wr_c  = 1'b1;
            default: ;
        endcase
    end

    // Offset-binary to two's complement is a flip of the MSB; the inverse is the same flip.
    assign x_in = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
    assign sum  = {x_q[DATA_W-1], x_q} + {rd_data_q[DATA_W-1], rd_data_q};
    assign y_mix = DATA_W'(sum >>> 1);

    // The read address uses the delay latched at sample start, so encoder motion mid-sample is deferred.
    assign rd_addr   = wr_ptr_q - dly_q;
    assign mem_we    = clr_we_c | (wr_c & en_q);
    assign mem_waddr = clr_we_c ? clr_cnt_q : wr_ptr_q;
    assign mem_wdata = clr_we_c ? '0 : y_q;

    // Delay buffer: one write port, one registered read port.
    always_ff @(posedge sclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem[rd_addr];
    end

    // Datapath: sample latch, mix result, output register, pointers and sticky overrun.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            clr_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            dly_q       <= ADDR_W'(DELAY_RST);
            x_q         <= '0;
            mode_q      <= 1'b0;
            en_q        <= 1'b0;
            y_q         <= '0;
            dac_data_q  <= MID;
            dac_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dac_valid_q <= wr_c;
            if (clr_we_c) begin
                clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            end
            if (latch_c) begin
                x_q    <= x_in;
                mode_q <= mode;
                en_q   <= en;
                dly_q  <= enc_delay;
            end
            if (mix_c) begin
                y_q <= mode_q ? y_mix : x_q;
            end
            if (wr_c) begin
                dac_data_q <= en_q ? {~y_q[DATA_W-1], y_q[DATA_W-2:0]} : MID;
                if (en_q) begin
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                end
            end
            if (sample_in && (state_q != ST_IDLE) && (state_q != ST_CLEAR)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign dac_data  = dac_data_q;
    assign dac_valid = dac_valid_q;
    assign delay     = enc_delay;
    assign ready     = ready_c;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_processor.sv
// tb/tb_echo_processor.sv - randomized scoreboard bench for echo_processor
module tb_echo_processor;

    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        mode = 1'b0;
    logic        encA = 1'b0;
    logic        encB = 1'b0;
    logic        sample_in = 1'b0;
    logic [11:0] adc_data = 12'h000;
    logic [11:0] dac_data;
    logic        dac_valid;
    logic [7:0]  delay;
    logic        ready;
    logic        overrun;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [11:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int mbuf [256];
    int mwp;
    int mdly;

    echo_processor dut (
        .sclk      (sclk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .encA      (encA),
        .encB      (encB),
        .sample_in (sample_in),
        .adc_data  (adc_data),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .delay     (delay),
        .ready     (ready),
        .overrun   (overrun)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed samples in a circular array, echo read 'delay' entries behind the write slot.
    task automatic model_sample(input logic [11:0] a, input logic m, input logic e, output logic [11:0] res);
        int x, d, y;
        if (!e) begin
            res = 12'h800;
            return;
        end
        x = int'(a) - 2048;
        d = mbuf[(mwp - mdly + 256) % 256];
        if (m) y = (x + d) >>> 1;
        else   y = x;
        mbuf[mwp] = y;
        mwp = (mwp + 1) % 256;
        res = 12'(y + 2048);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mbuf[i] = 0;
        mwp = 0;
        mdly = 64;
    endtask

    // Monitor: every output strobe must match the oldest outstanding expectation, on the right cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge sclk);
            if (dac_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_dac_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("dac_data", int'(dac_data), int'(e.data));
                    check("dac_valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(negedge sclk);
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [11:0] a, input logic m, input logic e);
        logic [11:0] r;
        exp_t x;
        wait_ready();
        @(negedge sclk);
        sample_in = 1'b1;
        adc_data = a;
        mode = m;
        en = e;
        @(posedge sclk);
        #1;
        model_sample(a, m, e, r);
        x.data = r;
        x.cyc = cyc + 3;
        sb.push_back(x);
        @(negedge sclk);
        sample_in = 1'b0;
        mode = ~m;
        en = ~e;
        repeat (4) @(negedge sclk);
    endtask

    task automatic enc_set(input logic [1:0] ab);
        @(negedge sclk);
        {encA, encB} = ab;
        repeat (4) @(negedge sclk);
    endtask

    task automatic step_up();
        enc_set(2'b01);
        enc_set(2'b00);
        if (mdly < 255) mdly++;
    endtask

    task automatic step_down();
        enc_set(2'b10);
        enc_set(2'b00);
        if (mdly > 1) mdly--;
    endtask

    // Apply reset, check reset values, then measure the clear sweep; a strobe during CLEAR must be ignored.
    task automatic do_reset();
        int n = 0;
        @(negedge sclk);
        reset = 1'b1;
        sample_in = 1'b0;
        {encA, encB} = 2'b00;
        repeat (3) @(negedge sclk);
        sb.delete();
        check("rst_dac_data", int'(dac_data), 12'h800);
        check("rst_dac_valid", int'(dac_valid), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_delay", int'(delay), 64);
        model_reset();
        reset = 1'b0;
        while (ready !== 1'b1 && n < 400) begin
            @(posedge sclk);
            #1;
            n++;
            if (n == 10) begin
                sample_in = 1'b1;
                adc_data = 12'h5A5;
            end
            if (n == 11) sample_in = 1'b0;
        end
        check("ready_latency", n, 256);
        check("clear_no_overrun", int'(overrun), 0);
    endtask

    initial begin
        logic [11:0] a2;
        exp_t x;
        logic [11:0] r;
        model_reset();
        do_reset();

        // Encoder saturation sweeps.
        for (int i = 0; i < 300; i++) step_up();
        check("delay_sat_high", int'(delay), 255);
        for (int i = 0; i < 300; i++) step_down();
        check("delay_sat_low", int'(delay), 1);
        enc_set(2'b11);
        enc_set(2'b00);
        check("delay_11_ignored", int'(delay), mdly);

        // Feedback echo with delay 1 on a cleared buffer: 0xFFF then 0x800.
        send(12'hFFF, 1'b1, 1'b1);
        send(12'h800, 1'b1, 1'b1);

        // Passthrough, muted sample, then an echo that shows the muted sample left the pointer alone.
        send(12'hABC, 1'b0, 1'b1);
        send(12'h123, 1'b1, 1'b0);
        send(12'h456, 1'b1, 1'b1);

        // Back-to-back strobes: one output, sticky overrun.
        check("overrun_before", int'(overrun), 0);
        wait_ready();
        @(negedge sclk);
        sample_in = 1'b1;
        adc_data = 12'h321;
        mode = 1'b1;
        en = 1'b1;
        @(posedge sclk);
        #1;
        model_sample(12'h321, 1'b1, 1'b1, r);
        x.data = r;
        x.cyc = cyc + 3;
        sb.push_back(x);
        @(negedge sclk);
        adc_data = 12'hFED;
        @(negedge sclk);
        sample_in = 1'b0;
        repeat (6) @(negedge sclk);
        check("overrun_set", int'(overrun), 1);

        // Randomized samples with encoder motion between them.
        for (int i = 0; i < 150; i++) begin
            int steps = $urandom_range(0, 3);
            for (int s = 0; s < steps; s++) begin
                if ($urandom_range(0, 2) != 0) step_up();
                else step_down();
            end
            if (steps != 0) check("delay_track", int'(delay), mdly);
            a2 = 12'($urandom_range(0, 4095));
            send(a2, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) != 0));
        end
        check("overrun_sticky", int'(overrun), 1);

        // Reset while the sample is in MIX: no output, buffer cleared again.
        wait_ready();
        @(negedge sclk);
        sample_in = 1'b1;
        adc_data = 12'h777;
        mode = 1'b1;
        en = 1'b1;
        @(posedge sclk);
        @(negedge sclk);
        sample_in = 1'b0;
        @(posedge sclk);
        #1;
        reset = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            a2 = 12'($urandom_range(0, 4095));
            send(a2, 1'b1, 1'b1);
        end

        repeat (10) @(negedge sclk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
